instr_mem_ctrl: RTL

Parametrised, loadable instruction memory for the Sloth core's fetch stage. It replaces the hard-wired combinational instruction table with a RAM-backed store. The store is zero-filled after reset, written through a programming port, and read by the fetch stage through a registered, stall-aware handshake. Out-of-range fetches return a default instruction and raise a flag.

---
 rtl/instr_mem_ctrl_pkg.sv | 11 +
 rtl/instr_mem_ctrl_array.sv | 34 +++
 rtl/instr_mem_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/instr_mem_ctrl_pkg.sv
// Shared settings for the Sloth instruction memory: core word width and FSM encodings.
package instr_mem_ctrl_pkg;

    localparam int unsigned CORE_WORD_WIDTH = 32;

    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } imc_state_e;

endpackage

// File: rtl/instr_mem_ctrl_array.sv
// Simple dual-port RAM: one write port, one synchronous read port, no reset on storage.
module instr_mem_array #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [WORD_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [WORD_WIDTH-1:0] o_rdata
);

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [WORD_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register only moves on an accepted fetch so the output holds otherwise.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Loadable instruction memory for the fetch stage: reset clear sweep, programming port,
// registered stall-aware fetch with out-of-range detection.
module instr_mem_ctrl
    import instr_mem_ctrl_pkg::*;
#(
    parameter int unsigned           WORD_WIDTH    = CORE_WORD_WIDTH,
    parameter int unsigned           DEPTH         = 256,
    parameter int unsigned           BYTE_ADDR     = 1,
    parameter logic [WORD_WIDTH-1:0] DEFAULT_INSTR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [WORD_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_stall,
    output logic                  fetch_ready,
    output logic [WORD_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  instr_oob,
    input  logic                  prog_we,
    input  logic [WORD_WIDTH-1:0] prog_addr,
    input  logic [WORD_WIDTH-1:0] prog_data,
    output logic                  prog_err,
    output logic                  busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    imc_state_e r_state;
    imc_state_e w_state_next;

    logic [IDX_W-1:0]      r_clr_cnt;
    logic                  r_instr_valid;
    logic                  r_instr_oob;
    logic                  r_use_default;
    logic                  r_prog_err;

    logic [WORD_WIDTH-1:0] w_fetch_word;
    logic [WORD_WIDTH-1:0] w_prog_word;
    logic                  w_fetch_in_range;
    logic                  w_prog_in_range;
    logic                  w_accept;
    logic                  w_clearing;
    logic                  w_clr_last;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_mem_waddr;
    logic [WORD_WIDTH-1:0] w_mem_wdata;
    logic [WORD_WIDTH-1:0] w_rdata;

    // Full-width index compare: high address bits never alias into the array.
    assign w_fetch_word     = (BYTE_ADDR != 0) ? (fetch_addr >> 2) : fetch_addr;
    assign w_prog_word      = (BYTE_ADDR != 0) ? (prog_addr >> 2) : prog_addr;
    assign w_fetch_in_range = (w_fetch_word < WORD_WIDTH'(DEPTH));
    assign w_prog_in_range  = (w_prog_word < WORD_WIDTH'(DEPTH));

    assign w_clearing = (r_state == StClear);
    assign w_clr_last = (r_clr_cnt == IDX_W'(DEPTH - 1));
    assign fetch_ready = (r_state == StRun) && !prog_we;
    assign w_accept    = fetch_req && fetch_ready && !fetch_stall;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StClear: if (w_clr_last) w_state_next = StRun;
            StRun:   w_state_next = StRun;
            default: w_state_next = StClear;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StClear;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_clearing) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // The sweep owns the write port during CLEAR; the programming port only in RUN.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = w_prog_word[IDX_W-1:0];
        w_mem_wdata = prog_data;
        if (w_clearing) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_clr_cnt;
            w_mem_wdata = DEFAULT_INSTR;
        end else if (prog_we && w_prog_in_range) begin
            w_mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_valid <= 1'b0;
            r_instr_oob   <= 1'b0;
            r_use_default <= 1'b1;
            r_prog_err    <= 1'b0;
        end else begin
            r_prog_err <= prog_we && (w_clearing || !w_prog_in_range);
            if (!fetch_stall) begin
                r_instr_valid <= w_accept;
                r_instr_oob   <= w_accept && !w_fetch_in_range;
                if (w_accept) begin
                    r_use_default <= !w_fetch_in_range;
                end
            end
        end
    end

    instr_mem_array #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_accept),
        .i_raddr (w_fetch_word[IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

    assign instr       = r_use_default ? DEFAULT_INSTR : w_rdata;
    assign instr_valid = r_instr_valid;
    assign instr_oob   = r_instr_oob;
    assign prog_err    = r_prog_err;
    assign busy        = w_clearing;

endmodule
